// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed byte stream (LEN_HI, LEN_LO, payload, CHK),
// assembles big-endian 32-bit words and writes them into instruction memory.
// The core stays held in reset until a checksum-verified program is loaded.
module imem_boot_loader #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [31:0]       im_wdata_o,
    output logic              cpu_hold_o,
    output logic              load_done_o,
    output logic              load_err_o,
    output logic [15:0]       words_loaded_o
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          len_hi_q, len_hi_d;
    logic [15:0]         len_q, len_d;
    logic [7:0]          chk_q, chk_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [23:0]         word_q, word_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [15:0]         words_q, words_d;
    logic                rx_ready_q, rx_ready_d;
    logic                im_we_q, im_we_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [31:0]         im_wdata_q, im_wdata_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                load_done_q, load_done_d;
    logic                load_err_q, load_err_d;

    logic                accept_c;
    logic [15:0]         len_full_c;

    assign accept_c   = rx_valid_i & rx_ready_q;
    assign len_full_c = {len_hi_q, rx_data_i};

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        chk_d       = chk_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        tmo_d       = tmo_q;
        words_d     = words_q;
        im_we_d     = 1'b0;
        im_addr_d   = im_addr_q;
        im_wdata_d  = im_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    state_d    = S_LEN_HI;
                    words_d    = 16'd0;
                    chk_d      = 8'd0;
                    byte_cnt_d = 2'd0;
                end
            end
            S_LEN_HI: begin
                if (accept_c) begin
                    len_hi_d = rx_data_i;
                    chk_d    = chk_q ^ rx_data_i;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept_c) begin
                    len_d = len_full_c;
                    chk_d = chk_q ^ rx_data_i;
                    if (len_full_c > 16'(DEPTH)) begin
                        state_d = S_ERROR;
                    end else if (len_full_c == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    chk_d      = chk_q ^ rx_data_i;
                    word_d     = {word_q[15:0], rx_data_i};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        im_we_d    = 1'b1;
                        im_addr_d  = words_q[ADDR_W-1:0];
                        im_wdata_d = {word_q, rx_data_i};
                        words_d    = words_q + 16'd1;
                        if ((words_q + 16'd1) == len_q) begin
                            state_d = S_CHK;
                        end
                    end
                end
            end
            S_CHK: begin
                if (accept_c) begin
                    state_d = (rx_data_i == chk_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Inter-byte idle watchdog, active only once a frame has begun
        if (state_q == S_LEN_LO || state_q == S_DATA || state_q == S_CHK) begin
            if (accept_c) begin
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
                if (tmo_d == TMO_W'(TIMEOUT)) begin
                    state_d = S_ERROR;
                end
            end
        end else begin
            tmo_d = '0;
        end

        rx_ready_d  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                      (state_d == S_DATA)   || (state_d == S_CHK);
        cpu_hold_d  = (state_d != S_DONE);
        load_done_d = (state_d == S_DONE);
        load_err_d  = (state_d == S_ERROR);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_hi_q    <= 8'd0;
            len_q       <= 16'd0;
            chk_q       <= 8'd0;
            byte_cnt_q  <= 2'd0;
            word_q      <= 24'd0;
            tmo_q       <= '0;
            words_q     <= 16'd0;
            rx_ready_q  <= 1'b0;
            im_we_q     <= 1'b0;
            im_addr_q   <= '0;
            im_wdata_q  <= 32'd0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            len_q       <= len_d;
            chk_q       <= chk_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            tmo_q       <= tmo_d;
            words_q     <= words_d;
            rx_ready_q  <= rx_ready_d;
            im_we_q     <= im_we_d;
            im_addr_q   <= im_addr_d;
            im_wdata_q  <= im_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign rx_ready_o     = rx_ready_q;
    assign im_we_o        = im_we_q;
    assign im_addr_o      = im_addr_q;
    assign im_wdata_o     = im_wdata_q;
    assign cpu_hold_o     = cpu_hold_q;
    assign load_done_o    = load_done_q;
    assign load_err_o     = load_err_q;
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader (TIMEOUT shortened to 8).
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_loaded;

    int vectors = 0;
    int errors  = 0;

    // Write log filled from the DUT write port
    int          wr_cnt = 0;
    logic [7:0]  wr_addr [0:15];
    logic [31:0] wr_data [0:15];

    logic [7:0]  frm [0:15];
    int          frm_len;

    imem_boot_loader #(.ADDR_W(8), .DEPTH(256), .TIMEOUT(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .rx_valid_i     (rx_valid),
        .rx_data_i      (rx_data),
        .rx_ready_o     (rx_ready),
        .im_we_o        (im_we),
        .im_addr_o      (im_addr),
        .im_wdata_o     (im_wdata),
        .cpu_hold_o     (cpu_hold),
        .load_done_o    (load_done),
        .load_err_o     (load_err),
        .words_loaded_o (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (im_we && wr_cnt < 16) begin
            wr_addr[wr_cnt] = im_addr;
            wr_data[wr_cnt] = im_wdata;
            wr_cnt++;
        end
    end

    task automatic start_pulse();
        wr_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; bounded wait for acceptance
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rx_ready) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL byte_accept data=%02h got no accept want accept", b);
        end
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < frm_len; i++) send_byte(frm[i], (i == 0) ? 0 : gap);
    endtask

    task automatic load_good_frame(input logic [7:0] chk);
        frm[0] = 8'h00; frm[1] = 8'h02;
        frm[2] = 8'h3C; frm[3] = 8'h10; frm[4] = 8'hFF; frm[5] = 8'hFF;
        frm[6] = 8'h36; frm[7] = 8'h10; frm[8] = 8'h00; frm[9] = 8'h01;
        frm[10] = chk;
        frm_len = 11;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_hold got %0b want 1", cpu_hold); end
        vectors++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", rx_ready); end
        vectors++; if ({load_done, load_err, im_we} !== 3'b000) begin errors++; $display("FAIL reset_flags got %03b want 000", {load_done, load_err, im_we}); end
        vectors++; if ({im_addr, im_wdata, words_loaded} !== 56'd0) begin errors++; $display("FAIL reset_bus got %h want 0", {im_addr, im_wdata, words_loaded}); end
    endtask

    task automatic test_normal();
        start_pulse();
        vectors++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL normal_ready got %0b want 1", rx_ready); end
        load_good_frame(8'h09);
        send_frame(0);
        vectors++; if (wr_cnt !== 2) begin errors++; $display("FAIL normal_wrcnt got %0d want 2", wr_cnt); end
        vectors++; if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h3C10FFFF) begin errors++; $display("FAIL normal_w0 got %0d:%h want 0:3c10ffff", wr_addr[0], wr_data[0]); end
        vectors++; if (wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h36100001) begin errors++; $display("FAIL normal_w1 got %0d:%h want 1:36100001", wr_addr[1], wr_data[1]); end
        vectors++; if ({load_done, load_err, cpu_hold} !== 3'b100) begin errors++; $display("FAIL normal_status got %03b want 100", {load_done, load_err, cpu_hold}); end
        vectors++; if (words_loaded !== 16'd2) begin errors++; $display("FAIL normal_words got %0d want 2", words_loaded); end
        vectors++; if (im_addr !== 8'd1 || im_wdata !== 32'h36100001 || im_we !== 1'b0) begin errors++; $display("FAIL normal_hold_bus got %0d:%h we=%0b want 1:36100001 we=0", im_addr, im_wdata, im_we); end
        vectors++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL normal_ready_done got %0b want 0", rx_ready); end
    endtask

    task automatic test_bad_checksum();
        start_pulse();
        vectors++; if ({load_done, cpu_hold} !== 2'b01) begin errors++; $display("FAIL restart_status got %02b want 01", {load_done, cpu_hold}); end
        load_good_frame(8'h0A);
        send_frame(0);
        vectors++; if (wr_cnt !== 2) begin errors++; $display("FAIL badchk_wrcnt got %0d want 2", wr_cnt); end
        vectors++; if ({load_done, load_err, cpu_hold} !== 3'b011) begin errors++; $display("FAIL badchk_status got %03b want 011", {load_done, load_err, cpu_hold}); end
        vectors++; if (words_loaded !== 16'd2) begin errors++; $display("FAIL badchk_words got %0d want 2", words_loaded); end
    endtask

    task automatic test_oversize();
        start_pulse();
        vectors++; if (load_err !== 1'b0) begin errors++; $display("FAIL over_errclr got %0b want 0", load_err); end
        frm[0] = 8'h01; frm[1] = 8'h01; frm_len = 2;
        send_frame(0);
        vectors++; if ({load_err, cpu_hold, rx_ready} !== 3'b110) begin errors++; $display("FAIL over_status got %03b want 110", {load_err, cpu_hold, rx_ready}); end
        rx_valid = 1'b1; rx_data = 8'h3C;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        vectors++; if (rx_ready !== 1'b0 || wr_cnt !== 0 || words_loaded !== 16'd0) begin errors++; $display("FAIL over_nowrite got ready=%0b wr=%0d words=%0d want 0 0 0", rx_ready, wr_cnt, words_loaded); end
    endtask

    task automatic test_zero_len();
        start_pulse();
        frm[0] = 8'h00; frm[1] = 8'h00; frm[2] = 8'h00; frm_len = 3;
        send_frame(0);
        vectors++; if ({load_done, load_err, cpu_hold} !== 3'b100) begin errors++; $display("FAIL zero_status got %03b want 100", {load_done, load_err, cpu_hold}); end
        vectors++; if (wr_cnt !== 0 || words_loaded !== 16'd0) begin errors++; $display("FAIL zero_words got wr=%0d words=%0d want 0 0", wr_cnt, words_loaded); end
        start_pulse();
        frm[2] = 8'h01;
        send_frame(0);
        vectors++; if ({load_done, load_err, cpu_hold} !== 3'b011) begin errors++; $display("FAIL zero_badchk got %03b want 011", {load_done, load_err, cpu_hold}); end
    endtask

    task automatic test_gaps();
        start_pulse();
        load_good_frame(8'h09);
        send_frame(7);
        vectors++; if ({load_done, load_err} !== 2'b10 || wr_cnt !== 2) begin errors++; $display("FAIL gap7_status got done/err=%02b wr=%0d want 10 2", {load_done, load_err}, wr_cnt); end
    endtask

    task automatic test_timeout();
        start_pulse();
        load_good_frame(8'h09);
        frm_len = 7;
        send_frame(0);
        repeat (7) @(negedge clk);
        vectors++; if (load_err !== 1'b0 || rx_ready !== 1'b1) begin errors++; $display("FAIL tmo_early got err=%0b ready=%0b want 0 1", load_err, rx_ready); end
        @(negedge clk);
        vectors++; if ({load_err, cpu_hold, rx_ready} !== 3'b110) begin errors++; $display("FAIL tmo_status got %03b want 110", {load_err, cpu_hold, rx_ready}); end
        vectors++; if (words_loaded !== 16'd1) begin errors++; $display("FAIL tmo_words got %0d want 1", words_loaded); end
    endtask

    task automatic test_reset_midload();
        start_pulse();
        frm[0] = 8'h00; frm[1] = 8'h02; frm[2] = 8'h3C; frm[3] = 8'h10; frm_len = 4;
        send_frame(0);
        rx_valid = 1'b1; rx_data = 8'hFF;
        #2 rst_n = 1'b0;
        #1;
        rx_valid = 1'b0;
        vectors++; if (cpu_hold !== 1'b1 || rx_ready !== 1'b0) begin errors++; $display("FAIL midrst_hold got hold=%0b ready=%0b want 1 0", cpu_hold, rx_ready); end
        vectors++; if ({load_done, load_err, im_we} !== 3'b000 || {im_addr, im_wdata, words_loaded} !== 56'd0) begin errors++; $display("FAIL midrst_outs got %h want 0", {load_done, load_err, im_we, im_addr, im_wdata, words_loaded}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_pulse();
        load_good_frame(8'h09);
        send_frame(0);
        vectors++; if (wr_cnt !== 2 || wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h3C10FFFF) begin errors++; $display("FAIL midrst_reload got wr=%0d %0d:%h want 2 0:3c10ffff", wr_cnt, wr_addr[0], wr_data[0]); end
        vectors++; if ({load_done, cpu_hold} !== 2'b10 || words_loaded !== 16'd2) begin errors++; $display("FAIL midrst_done got %02b words=%0d want 10 2", {load_done, cpu_hold}, words_loaded); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bad_checksum();
        test_oversize();
        test_zero_len();
        test_gaps();
        test_timeout();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream boot stage for the single-cycle MIPS core.
- Takes a framed byte stream (e.g. from a UART receiver) over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes those words into the instruction memory write port.
- Holds the core in reset until a complete, checksum-verified program has been loaded.

Parameters:
- ADDR_W, 8, instruction memory word-address width.
- DEPTH, 256, maximum program length in words (must be ≤ 2^ADDR_W).
- TIMEOUT, 1000, maximum idle cycles between accepted bytes inside a frame before abort.

Ports:
- Clk  in  1  system clock, all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a new load when in IDLE, DONE or ERROR.
- rx_valid  in  1  rx_data holds a byte.
- rx_data  in  8  incoming byte.
- rx_ready  out  1  loader can accept a byte this cycle.
- im_we  out  1  instruction memory write strobe, one cycle per word.
- im_addr  out  ADDR_W  word index being written.
- im_wdata  out  32  instruction word being written.
- cpu_hold  out  1  drives the core's reset; 1 holds the core.
- load_done  out  1  level; program loaded and verified.
- load_err  out  1  level; last load failed.
- words_loaded  out  16  count of words written in the current or last load.

Behaviour:
- Frame format: LEN_HI, LEN_LO, then 4×LEN payload bytes, then CHK.
  - Payload words are big-endian: first byte goes to [31:24].
  - CHK must equal the XOR of every preceding frame byte, including both length bytes.
- Reset (Reset=0, asynchronous) forces:
  - state=IDLE, cpu_hold=1, all other outputs 0.
  - Internal byte counter, length, checksum and timeout counter cleared.
- A byte is accepted on a rising edge where rx_valid & rx_ready. rx_ready is registered-state decoded: 1 only in LEN_HI, LEN_LO, DATA, CHK.
- IDLE:
  - start → LEN_HI; clear words_loaded and checksum; cpu_hold=1, load_done=0, load_err=0.
- LEN_HI:
  - On accept, store the high length byte → LEN_LO.
  - No timeout applies in LEN_HI; it waits indefinitely.
- LEN_LO:
  - On accept, form the 16-bit LEN.
  - LEN > DEPTH → ERROR; no writes are issued.
  - LEN = 0 → CHK.
  - Otherwise → DATA.
- DATA:
  - Shift each accepted byte into the word assembler.
  - On the 4th byte, the next cycle drives im_we=1 for exactly one cycle, with im_addr = word index (starting at 0) and im_wdata = the assembled word.
  - words_loaded increments in the same cycle as im_we.
  - After word LEN-1's byte 4 → CHK.
  - A new byte may be accepted in the same cycle im_we is high; there are no bubbles required.
- CHK:
  - On accept, compare with the running XOR.
  - Match → DONE; mismatch → ERROR.
- DONE: load_done=1, cpu_hold=0.
- ERROR: load_err=1, cpu_hold=1. Words already written stay in memory; the core never runs them.
- Timeout:
  - In LEN_LO, DATA or CHK, the counter increments each cycle without an accepted byte and clears on accept.
  - Reaching TIMEOUT → ERROR.
- start handling:
  - Ignored in LEN_HI..CHK.
  - In DONE or ERROR it restarts the load: cpu_hold returns to 1 on the next edge and load_done/load_err clear.
- Simultaneous start and rx_valid in IDLE/DONE/ERROR: no byte is accepted that cycle (rx_ready=0).
- im_addr and im_wdata hold their last values when im_we=0.
- Arithmetic and widths:
  - Word index is ADDR_W bits and never wraps, because LEN ≤ DEPTH is enforced.
  - words_loaded is 16 bits.

Test Plan:
- Normal load: start, then bytes 00 02 3C 10 FF FF 36 10 00 01 09 with rx_valid held high → im_we pulses at addr 0 (3C10FFFF) and addr 1 (36100001); then load_done=1, cpu_hold=0, words_loaded=2.
- Bad checksum: same frame with CHK=0x0A → both writes occur; load_err=1, cpu_hold=1, load_done=0.
- Oversize: LEN=0x0101 with DEPTH=256 → ERROR right after LEN_LO; no im_we; rx_ready=0 thereafter.
- Zero length: 00 00 00 → DONE with no im_we and words_loaded=0; a frame of 00 00 01 → ERROR.
- Gaps and timeout (TIMEOUT=8):
  - Insert 7 idle cycles between payload bytes of the 2-word frame → DONE.
  - Stall 8 cycles after the 5th byte → ERROR, words_loaded=1.
- Reset mid-load: assert Reset low during byte 3 of the payload → all outputs 0 immediately except cpu_hold=1. After release, start plus a fresh frame completes normally from addr 0.
